ctrl_sequencer: RTL
===================

// Module: ctrl_sequencer
// PURPOSE
//  Next-generation control unit: wraps the combinational instruction decoder in a
//  fetch/execute FSM. Adds multi-cycle loads with parametrised memory latency, an
//  internal auto-advancing substring index for sbs/dbs, and a done/Ack handshake.
//  Sits between instruction ROM/PC and the regfile/ALU/data-mem/PC-reg datapath.
// PARAMETERS
//  IW       9  instruction width
//  RAW      4  register address width (2**RAW registers, r0 reads as 0)
//  PCRW     2  PC-register select width
//  SUBW     2  substring index width (index wraps at 2**SUBW)
//  MEM_LAT  2  data-mem read latency in cycles (0 = combinational read)
// PORTS
//  Clk             in   1     clock, rising edge
//  Reset           in   1     asynchronous, active-high
//  Start           in   1     begin execution (IDLE) / restart (HALT)
//  Instruction     in   IW    current instruction from ROM at PC
//  PCEn            out  1     advance PC this cycle
//  Busy            out  1     1 in EXEC or MEMWAIT
//  Ack             out  1     registered; program reached DONE
//  SubstringIndex  out  SUBW  current substring index to ALU
//  PCRegSelect     out  PCRW  PC register select
//  WriteSource     out  3     regfile write mux select
//  ReadRegAddrA    out  RAW   read port A address
//  ReadRegAddrB    out  RAW   read port B address
//  WriteRegAddr    out  RAW   write address
//  ALUOp           out  4     ALU operation
//  ImmOut          out  8     zero-extended immediate
//  JumpEqual       out  1     branch if zero flag set
//  JumpNotEqual    out  1     branch if zero flag clear
//  OffsetEn        out  1     PC-reg store uses PC+offset
//  RegWrEn         out  1     regfile write enable
//  MemWrEn         out  1     data-mem write enable
// BEHAVIOUR
//  - Reset (any time, incl. mid-load): state IDLE, wait counter 0, SubstringIndex 0,
//    Ack 0. All enables and PCEn 0; address/select/ALUOp/ImmOut outputs 0.
//  - FSM: IDLE -Start-> EXEC; EXEC -load & MEM_LAT>0-> MEMWAIT;
//    MEMWAIT -counter==0-> EXEC; EXEC -DONE-> HALT; HALT -Start-> EXEC.
//    Start ignored in EXEC/MEMWAIT.
//  - Decode fields and encodings are unchanged from the current decoder. In EXEC
//    every field output is combinational from Instruction, zero added latency.
//    RegWrEn, MemWrEn, JumpEqual, JumpNotEqual, OffsetEn are forced 0 outside EXEC,
//    except RegWrEn in the final MEMWAIT cycle.
//  - Non-load in EXEC: decoded enables asserted 1 cycle, PCEn=1.
//  - Load (01000_rrr_0) in EXEC with MEM_LAT>0: RegWrEn=0, PCEn=0, counter<=MEM_LAT-1,
//    go MEMWAIT. MEMWAIT holds the decode of the held Instruction and counts down.
//    When counter==0: RegWrEn=1, PCEn=1, return to EXEC. Load total = MEM_LAT+1 cycles.
//    MEM_LAT=0: load is single-cycle.
//  - sbs (01010) / dbs (01011): ALUOp=kSBS/kDBS. ALU consumes SubstringIndex this
//    cycle; index increments at the clock edge, 2**SUBW-1 -> 0.
//    SubstringIndex is cleared by Reset and by Start in HALT.
//  - DONE = Instruction=='1. Raises Ack at the next edge with no writes and PCEn=0.
//    Immediate mov of 5'b11111 is therefore reserved. Ack is held through HALT and
//    cleared on the edge that leaves HALT.
//  - Busy = (state==EXEC || state==MEMWAIT).
// STRUCTURE
//  - Shared package definitions: ALUOp constants (kADD kSUB kLSH kRSH kORR kRXR
//    kSBS kDBS), opcode constants, kDONE, state enum ctrl_state_t {IDLE,EXEC,MEMWAIT,HALT}.
//  - Sub-module ctrl_decode: pure combinational decode (Instruction, SubstringIndex ->
//    fields + raw enables), parametrised IW/RAW/PCRW.
//  - ctrl_sequencer holds the FSM, wait counter, index counter, Ack flop and enable gating.
// TESTING
//  1 Reset, then Instruction=add r4(1110_100_0_0) with no Start -> RegWrEn=0, PCEn=0, Busy=0.
//  2 Start, then add r4 -> RegWrEn=1, ALUOp=kADD, WriteRegAddr=4, PCEn=1 same cycle.
//  3 MEM_LAT=2, Instruction ld r2 -> cycles 1-2 RegWrEn=0/PCEn=0; cycle 3
//    RegWrEn=1, WriteSource=3'b001, WriteRegAddr=2, PCEn=1.
//  4 Five consecutive dbs r3 -> SubstringIndex 0,1,2,3,0. ALUOp=kDBS on each.
//  5 Instruction=9'h1FF -> Ack=1 next edge, held; PCEn=0. Start -> Ack=0, index=0, EXEC.
//  6 Assert Reset in cycle 2 of a MEM_LAT=2 load -> immediately IDLE, RegWrEn=0,
//    SubstringIndex=0. No write on the following edge.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the control sequencer: ALU operations, opcodes,
// regfile write sources and FSM states.
package ctrl_sequencer_pkg;

  localparam logic [3:0] kADD = 4'd0;
  localparam logic [3:0] kSUB = 4'd1;
  localparam logic [3:0] kLSH = 4'd2;
  localparam logic [3:0] kRSH = 4'd3;
  localparam logic [3:0] kORR = 4'd4;
  localparam logic [3:0] kRXR = 4'd5;
  localparam logic [3:0] kSBS = 4'd6;
  localparam logic [3:0] kDBS = 4'd7;

  // Instructions with bit 8 set use a 4-bit opcode, the rest a 5-bit opcode.
  localparam logic [3:0] kOpSub  = 4'b1000;
  localparam logic [3:0] kOpLsh  = 4'b1001;
  localparam logic [3:0] kOpRsh  = 4'b1010;
  localparam logic [3:0] kOpOrr  = 4'b1011;
  localparam logic [3:0] kOpRxr  = 4'b1100;
  localparam logic [3:0] kOpAdd  = 4'b1110;
  localparam logic [3:0] kOpMovi = 4'b1111;

  localparam logic [4:0] kOpBeq = 5'b00100;
  localparam logic [4:0] kOpBne = 5'b00101;
  localparam logic [4:0] kOpSpc = 5'b00110;
  localparam logic [4:0] kOpMov = 5'b00111;
  localparam logic [4:0] kOpLd  = 5'b01000;
  localparam logic [4:0] kOpSt  = 5'b01001;
  localparam logic [4:0] kOpSbs = 5'b01010;
  localparam logic [4:0] kOpDbs = 5'b01011;

  localparam logic [2:0] kWsAlu = 3'b000;
  localparam logic [2:0] kWsMem = 3'b001;
  localparam logic [2:0] kWsImm = 3'b010;
  localparam logic [2:0] kWsReg = 3'b011;

  // All-ones word ends the program; shadows "movi 5'b11111".
  localparam logic [8:0] kDONE = 9'h1FF;

  typedef enum logic [1:0] {IDLE, EXEC, MEMWAIT, HALT} ctrl_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: fields and raw (ungated) enables.
module ctrl_decode
  import ctrl_sequencer_pkg::*;
#(
  parameter int unsigned IW   = 9,
  parameter int unsigned RAW  = 4,
  parameter int unsigned PCRW = 2,
  parameter int unsigned SUBW = 2
) (
  input  logic [IW-1:0]   Instruction,
  input  logic [SUBW-1:0] SubstringIndex,
  output logic [PCRW-1:0] PCRegSelect,
  output logic [2:0]      WriteSource,
  output logic [RAW-1:0]  ReadRegAddrA,
  output logic [RAW-1:0]  ReadRegAddrB,
  output logic [RAW-1:0]  WriteRegAddr,
  output logic [3:0]      ALUOp,
  output logic [7:0]      ImmOut,
  output logic            JumpEqualRaw,
  output logic            JumpNotEqualRaw,
  output logic            OffsetEnRaw,
  output logic            RegWrEnRaw,
  output logic            MemWrEnRaw,
  output logic            IsLoad,
  output logic            IsSubstr
);

  always_comb begin
    PCRegSelect     = '0;
    WriteSource     = kWsAlu;
    ReadRegAddrA    = '0;
    ReadRegAddrB    = '0;
    WriteRegAddr    = '0;
    ALUOp           = kADD;
    ImmOut          = '0;
    JumpEqualRaw    = 1'b0;
    JumpNotEqualRaw = 1'b0;
    OffsetEnRaw     = 1'b0;
    RegWrEnRaw      = 1'b0;
    MemWrEnRaw      = 1'b0;
    IsLoad          = 1'b0;
    IsSubstr        = 1'b0;
    if (Instruction[8]) begin
      // Register ALU ops: rrr op= r1.
      ReadRegAddrA = RAW'(Instruction[4:2]);
      ReadRegAddrB = RAW'(1);
      WriteRegAddr = RAW'(Instruction[4:2]);
      RegWrEnRaw   = 1'b1;
      case (Instruction[8:5])
        kOpSub:  ALUOp = kSUB;
        kOpLsh:  ALUOp = kLSH;
        kOpRsh:  ALUOp = kRSH;
        kOpOrr:  ALUOp = kORR;
        kOpRxr:  ALUOp = kRXR;
        kOpAdd:  ALUOp = kADD;
        kOpMovi: begin
          ReadRegAddrA = '0;
          ReadRegAddrB = '0;
          WriteRegAddr = RAW'(1);
          WriteSource  = kWsImm;
          ImmOut       = 8'(Instruction[4:0]);
        end
        default: begin
          ReadRegAddrA = '0;
          ReadRegAddrB = '0;
          WriteRegAddr = '0;
          RegWrEnRaw   = 1'b0;
        end
      endcase
    end else begin
      case (Instruction[8:4])
        kOpBeq: begin
          PCRegSelect  = PCRW'(Instruction[3:2]);
          JumpEqualRaw = 1'b1;
        end
        kOpBne: begin
          PCRegSelect     = PCRW'(Instruction[3:2]);
          JumpNotEqualRaw = 1'b1;
        end
        kOpSpc: begin
          PCRegSelect = PCRW'(Instruction[3:2]);
          OffsetEnRaw = Instruction[1];
        end
        kOpMov: begin
          ReadRegAddrA = RAW'(Instruction[3:1]);
          WriteRegAddr = RAW'(1);
          WriteSource  = kWsReg;
          RegWrEnRaw   = 1'b1;
        end
        kOpLd: begin
          ReadRegAddrA = RAW'(1);
          WriteRegAddr = RAW'(Instruction[3:1]);
          WriteSource  = kWsMem;
          RegWrEnRaw   = 1'b1;
          IsLoad       = 1'b1;
        end
        kOpSt: begin
          ReadRegAddrA = RAW'(1);
          ReadRegAddrB = RAW'(Instruction[3:1]);
          MemWrEnRaw   = 1'b1;
        end
        kOpSbs, kOpDbs: begin
          ReadRegAddrA = RAW'(Instruction[3:1]);
          ReadRegAddrB = RAW'(1);
          WriteRegAddr = RAW'(Instruction[3:1]);
          ALUOp        = Instruction[4] ? kDBS : kSBS;
          ImmOut       = 8'(SubstringIndex);
          RegWrEnRaw   = 1'b1;
          IsSubstr     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/execute sequencer: gates decoder enables through an FSM with multi-cycle
// loads, an auto-advancing substring index and a done/Ack handshake.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int unsigned IW      = 9,
  parameter int unsigned RAW     = 4,
  parameter int unsigned PCRW    = 2,
  parameter int unsigned SUBW    = 2,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [IW-1:0]   Instruction,
  output logic            PCEn,
  output logic            Busy,
  output logic            Ack,
  output logic [SUBW-1:0] SubstringIndex,
  output logic [PCRW-1:0] PCRegSelect,
  output logic [2:0]      WriteSource,
  output logic [RAW-1:0]  ReadRegAddrA,
  output logic [RAW-1:0]  ReadRegAddrB,
  output logic [RAW-1:0]  WriteRegAddr,
  output logic [3:0]      ALUOp,
  output logic [7:0]      ImmOut,
  output logic            JumpEqual,
  output logic            JumpNotEqual,
  output logic            OffsetEn,
  output logic            RegWrEn,
  output logic            MemWrEn
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  ctrl_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SUBW-1:0] idx_q, idx_d;
  logic            ack_q, ack_d;

  logic [PCRW-1:0] dec_pcsel;
  logic [2:0]      dec_wsrc;
  logic [RAW-1:0]  dec_ra, dec_rb, dec_wa;
  logic [3:0]      dec_aluop;
  logic [7:0]      dec_imm;
  logic            dec_jeq, dec_jne, dec_off, dec_rwe, dec_mwe, dec_load, dec_sub;

  ctrl_decode #(
    .IW   (IW),
    .RAW  (RAW),
    .PCRW (PCRW),
    .SUBW (SUBW)
  ) u_decode (
    .Instruction     (Instruction),
    .SubstringIndex  (idx_q),
    .PCRegSelect     (dec_pcsel),
    .WriteSource     (dec_wsrc),
    .ReadRegAddrA    (dec_ra),
    .ReadRegAddrB    (dec_rb),
    .WriteRegAddr    (dec_wa),
    .ALUOp           (dec_aluop),
    .ImmOut          (dec_imm),
    .JumpEqualRaw    (dec_jeq),
    .JumpNotEqualRaw (dec_jne),
    .OffsetEnRaw     (dec_off),
    .RegWrEnRaw      (dec_rwe),
    .MemWrEnRaw      (dec_mwe),
    .IsLoad          (dec_load),
    .IsSubstr        (dec_sub)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ack_d        = ack_q;
    PCEn         = 1'b0;
    PCRegSelect  = '0;
    WriteSource  = '0;
    ReadRegAddrA = '0;
    ReadRegAddrB = '0;
    WriteRegAddr = '0;
    ALUOp        = '0;
    ImmOut       = '0;
    JumpEqual    = 1'b0;
    JumpNotEqual = 1'b0;
    OffsetEn     = 1'b0;
    RegWrEn      = 1'b0;
    MemWrEn      = 1'b0;

    // Fields follow the decoder whenever an instruction is in flight.
    if (state_q == EXEC || state_q == MEMWAIT) begin
      PCRegSelect  = dec_pcsel;
      WriteSource  = dec_wsrc;
      ReadRegAddrA = dec_ra;
      ReadRegAddrB = dec_rb;
      WriteRegAddr = dec_wa;
      ALUOp        = dec_aluop;
      ImmOut       = dec_imm;
    end

    case (state_q)
      IDLE: begin
        if (Start) state_d = EXEC;
      end
      EXEC: begin
        if (Instruction == kDONE) begin
          state_d = HALT;
          ack_d   = 1'b1;
        end else if (dec_load && MEM_LAT > 0) begin
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = MEMWAIT;
        end else begin
          PCEn         = 1'b1;
          RegWrEn      = dec_rwe;
          MemWrEn      = dec_mwe;
          JumpEqual    = dec_jeq;
          JumpNotEqual = dec_jne;
          OffsetEn     = dec_off;
          if (dec_sub) idx_d = idx_q + SUBW'(1);
        end
      end
      MEMWAIT: begin
        if (cnt_q == '0) begin
          RegWrEn = dec_rwe;
          PCEn    = 1'b1;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HALT: begin
        if (Start) begin
          state_d = EXEC;
          ack_d   = 1'b0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy           = (state_q == EXEC) || (state_q == MEMWAIT);
  assign Ack            = ack_q;
  assign SubstringIndex = idx_q;

endmodule
